// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and defaults for the data-memory responder.
//   state_t : responder FSM states (IDLE, WAIT, RESP)
//   size_t  : RISC-V load/store funct3 size codes
//   DATA_W_DEF / ADDR_W_DEF : default data and byte-address widths
//   LANES   : byte lanes per storage word
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 9;
    localparam int LANES      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SIZE_B  = 3'b000,
        SIZE_H  = 3'b001,
        SIZE_W  = 3'b010,
        SIZE_BU = 3'b100,
        SIZE_HU = 3'b101
    } size_t;

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane logic for one memory access.
//   size    : funct3 size code of the access
//   addr_lo : low two byte-address bits (lane offset)
//   wdata   : LSB-aligned store data
//   rword   : full storage word at the accessed word address
//   wstrb   : per-lane write enables (all zero on an illegal access)
//   wword   : store data replicated onto the lanes it may land in
//   rdata   : extracted and extended load data (zero on an illegal access)
//   err     : misaligned access or unsupported size code
// Lanes are fixed at four bytes, so DATA_W is expected to be 32.
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [LANES-1:0]  wstrb,
    output logic [DATA_W-1:0] wword,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    logic [DATA_W-1:0] shifted;

    // NOTE: every output of a combinational block gets a default before the
    // case statements, so no path leaves a signal unassigned and no latch is
    // inferred.
    always_comb begin
        err     = 1'b0;
        wstrb   = '0;
        wword   = wdata;
        rdata   = '0;
        // Bring the addressed byte/half down to bit 0 before extension.
        shifted = rword >> {addr_lo, 3'b000};

        case (size)
            SIZE_B, SIZE_BU: begin
                wstrb = 4'b0001 << addr_lo;
                wword = {4{wdata[7:0]}};
            end
            SIZE_H, SIZE_HU: begin
                err   = addr_lo[0];
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
            end
            SIZE_W: begin
                err   = (addr_lo != 2'b00);
                wstrb = 4'b1111;
            end
            default: err = 1'b1;
        endcase

        case (size)
            SIZE_B:  rdata = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            SIZE_BU: rdata = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            SIZE_H:  rdata = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            SIZE_HU: rdata = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            SIZE_W:  rdata = rword;
            default: rdata = '0;
        endcase

        // An illegal access neither writes nor returns data.
        if (err) begin
            wstrb = '0;
            rdata = '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data-memory responder with configurable wait states.
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_wr               : 1 = store, 0 = load
//   req_addr             : byte address
//   req_size             : funct3 size code (b, h, w, bu, hu)
//   req_wdata            : LSB-aligned store data
//   rsp_valid            : one-cycle response strobe
//   rsp_rdata            : extended load data (0 for stores and errors)
//   rsp_err              : misaligned access or illegal size
//   busy                 : FSM outside IDLE
// Accepted requests spend WAIT_CYCLES cycles in WAIT, then one cycle in RESP.
// The memory access happens on the edge that enters RESP.
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int WORDS = 2 ** (ADDR_W - 2);

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;

    logic              cap_wr;
    logic [ADDR_W-1:0] cap_addr;
    logic [2:0]        cap_size;
    logic [DATA_W-1:0] cap_wdata;

    logic [LANES-1:0][7:0] mem [WORDS];

    logic              accept;
    logic              enter_resp;

    logic              acc_wr;
    logic [ADDR_W-1:0] acc_addr;
    logic [2:0]        acc_size;
    logic [DATA_W-1:0] acc_wdata;
    logic [ADDR_W-3:0] word_idx;
    logic [DATA_W-1:0] rword;

    logic [LANES-1:0]  la_wstrb;
    logic [DATA_W-1:0] la_wword;
    logic [DATA_W-1:0] la_rdata;
    logic              la_err;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_next = RESP;
                else             cnt_next   = cnt - 4'd1;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP);

    // With no wait states the access happens on the accepting edge, before
    // the capture registers hold the request, so the live request is used.
    assign acc_wr    = (state == IDLE) ? req_wr    : cap_wr;
    assign acc_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign acc_size  = (state == IDLE) ? req_size  : cap_size;
    assign acc_wdata = (state == IDLE) ? req_wdata : cap_wdata;

    assign word_idx = acc_addr[ADDR_W-1:2];
    assign rword    = mem[word_idx];

    dmem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .size    (acc_size),
        .addr_lo (acc_addr[1:0]),
        .wdata   (acc_wdata),
        .rword   (rword),
        .wstrb   (la_wstrb),
        .wword   (la_wword),
        .rdata   (la_rdata),
        .err     (la_err)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_wr    <= 1'b0;
            cap_addr  <= '0;
            cap_size  <= '0;
            cap_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                cap_wr    <= req_wr;
                cap_addr  <= req_addr;
                cap_size  <= req_size;
                cap_wdata <= req_wdata;
            end
            if (enter_resp) begin
                rsp_rdata <= acc_wr ? '0 : la_rdata;
                rsp_err   <= la_err;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; contents survive
    // reset, and a reset on the committing edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && acc_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (la_wstrb[i]) mem[word_idx][i] <= la_wword[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Three responders (WAIT_CYCLES = 1, 3, 0) driven against a byte-addressed
// reference memory kept in the bench.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_wr    [3];
    logic [8:0]  req_addr  [3];
    logic [2:0]  req_size  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    logic [7:0]  mdl [3][512];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .busy(busy[0])
    );

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .busy(busy[1])
    );

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_wr(req_wr[2]),
        .req_addr(req_addr[2]), .req_size(req_size[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
        .busy(busy[2])
    );

    function automatic int wc(input int idx);
        case (idx)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    // Reference rules: which accesses are illegal, and how many bytes move.
    function automatic bit m_err(input logic [2:0] sz, input logic [8:0] a);
        case (sz)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            3'b010:         return a[1:0] != 2'b00;
            default:        return 1'b1;
        endcase
    endfunction

    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Little-endian gather from the byte memory, then extension.
    function automatic logic [31:0] m_load(input int idx, input logic [2:0] sz,
                                           input logic [8:0] a);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nbytes(sz); i++) v = v | (32'(mdl[idx][int'(a) + i]) << (8 * i));
        if (sz == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (sz == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One complete request/response with timing, data and model update.
    task automatic txn(input int idx, input bit wr, input logic [8:0] addr,
                       input logic [2:0] sz, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        int          hs;
        int          rc;
        bit          got;
        bit          e_er;
        logic [31:0] e_rd;
        e_er = m_err(sz, addr);
        e_rd = (wr || e_er) ? 32'h0 : m_load(idx, sz, addr);
        @(negedge clk);
        req_wr[idx]    = wr;
        req_addr[idx]  = addr;
        req_size[idx]  = sz;
        req_wdata[idx] = wd;
        req_valid[idx] = 1'b1;
        got = 1'b0;
        hs  = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (req_ready[idx]) begin
                got = 1'b1;
                hs  = cyc;
            end else begin
                @(negedge clk);
            end
        end
        check($sformatf("d%0d_accept", idx), 32'(got), 32'd1);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        got = 1'b0;
        rc  = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (rsp_valid[idx]) begin
                got = 1'b1;
                rc  = cyc;
            end else begin
                @(negedge clk);
            end
        end
        check($sformatf("d%0d_rsp_seen", idx), 32'(got), 32'd1);
        rd = rsp_rdata[idx];
        er = rsp_err[idx];
        check($sformatf("d%0d_latency", idx), 32'(rc - hs), 32'(1 + wc(idx)));
        check($sformatf("d%0d_rdata", idx), rd, e_rd);
        check($sformatf("d%0d_err", idx), 32'(er), 32'(e_er));
        @(negedge clk);
        check($sformatf("d%0d_rsp_width", idx), 32'(rsp_valid[idx]), 32'd0);
        check($sformatf("d%0d_rdata_hold", idx), rsp_rdata[idx], e_rd);
        if (wr && !e_er) begin
            for (int i = 0; i < nbytes(sz); i++) mdl[idx][int'(addr) + i] = wd[8*i +: 8];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] old;
        logic [31:0] e;
        logic [2:0]  t_sz  [4];
        logic [8:0]  t_adr [4];
        logic [31:0] t_exp [4];
        int          acc_q [$];
        int          rsp_q [$];
        bit          prev_rv;
        int          dbl;
        int          rv_cnt;
        int          r;
        bit          wr;
        logic [2:0]  sz;
        logic [8:0]  ad;

        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            req_wr[k]    = 1'b0;
            req_addr[k]  = '0;
            req_size[k]  = '0;
            req_wdata[k] = '0;
        end

        // Reset state.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("d%0d_rst_rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
            check($sformatf("d%0d_rst_ready", k), 32'(req_ready[k]), 32'd1);
            check($sformatf("d%0d_rst_busy", k), 32'(busy[k]), 32'd0);
            check($sformatf("d%0d_rst_rdata", k), rsp_rdata[k], 32'd0);
            check($sformatf("d%0d_rst_err", k), 32'(rsp_err[k]), 32'd0);
        end
        reset = 1'b0;

        // Give every word a known value so the model covers all loads.
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 128; w++) begin
                txn(k, 1'b1, 9'(w * 4), 3'b010, $urandom, rd, er);
            end
        end

        // Word store/load and extension variants.
        txn(0, 1'b1, 9'h010, 3'b010, 32'hDEAD_BEEF, rd, er);
        txn(0, 1'b0, 9'h010, 3'b010, 32'h0, rd, er);
        check("w_load", rd, 32'hDEAD_BEEF);
        check("w_load_err", 32'(er), 32'd0);
        t_sz  = '{3'b000, 3'b100, 3'b101, 3'b001};
        t_adr = '{9'h013, 9'h013, 9'h012, 9'h010};
        t_exp = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'h0000_DEAD, 32'hFFFF_BEEF};
        for (int k = 0; k < 4; k++) begin
            txn(0, 1'b0, t_adr[k], t_sz[k], 32'h0, rd, er);
            check($sformatf("ext_%0d", k), rd, t_exp[k]);
        end

        // Misaligned half store is rejected and leaves memory untouched.
        txn(0, 1'b1, 9'h011, 3'b001, 32'h0000_1234, rd, er);
        check("mis_store_err", 32'(er), 32'd1);
        txn(0, 1'b0, 9'h010, 3'b010, 32'h0, rd, er);
        check("mis_store_kept", rd, 32'hDEAD_BEEF);

        // Reset during WAIT aborts a store.
        old = m_load(0, 3'b010, 9'h020);
        @(negedge clk);
        req_wr[0]    = 1'b1;
        req_addr[0]  = 9'h020;
        req_size[0]  = 3'b010;
        req_wdata[0] = 32'hA5A5_A5A5;
        req_valid[0] = 1'b1;
        check("abort_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("abort_busy_wait", 32'(busy[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_ready_after", 32'(req_ready[0]), 32'd1);
        check("abort_rdata", rsp_rdata[0], 32'd0);
        check("abort_err", 32'(rsp_err[0]), 32'd0);
        reset = 1'b0;
        rv_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[0]) rv_cnt++;
        end
        check("abort_no_rsp", 32'(rv_cnt), 32'd0);
        txn(0, 1'b0, 9'h020, 3'b010, 32'h0, rd, er);
        check("abort_mem_kept", rd, old);

        // Zero wait states with an illegal size code.
        txn(2, 1'b0, 9'h040, 3'b011, 32'h0, rd, er);
        check("w0_bad_size_err", 32'(er), 32'd1);
        check("w0_bad_size_rdata", rd, 32'd0);

        // Back-to-back requests with req_valid held high, WAIT_CYCLES = 3.
        e = m_load(1, 3'b010, 9'h000);
        @(negedge clk);
        req_wr[1]    = 1'b0;
        req_addr[1]  = 9'h000;
        req_size[1]  = 3'b010;
        req_valid[1] = 1'b1;
        prev_rv = 1'b0;
        dbl = 0;
        for (int i = 0; i < 40; i++) begin
            if (req_valid[1] && req_ready[1]) acc_q.push_back(cyc);
            if (rsp_valid[1]) begin
                rsp_q.push_back(cyc);
                check("tp_rdata", rsp_rdata[1], e);
                if (prev_rv) dbl++;
            end
            prev_rv = rsp_valid[1];
            if (acc_q.size() == 4 && !req_ready[1]) req_valid[1] = 1'b0;
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        check("tp_accepts", 32'(acc_q.size()), 32'd4);
        check("tp_rsps", 32'(rsp_q.size()), 32'd4);
        check("tp_rsp_one_cycle", 32'(dbl), 32'd0);
        for (int k = 1; k < acc_q.size(); k++) begin
            check("tp_interval", 32'(acc_q[k] - acc_q[k-1]), 32'd5);
        end
        for (int k = 0; k < acc_q.size() && k < rsp_q.size(); k++) begin
            check("tp_latency", 32'(rsp_q[k] - acc_q[k]), 32'd4);
        end

        // Randomized traffic, concentrated in a small window for reuse.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 80; n++) begin
                wr = 1'($urandom_range(0, 1));
                r  = int'($urandom_range(0, 9));
                case (r)
                    0:       sz = 3'b000;
                    1:       sz = 3'b001;
                    5:       sz = 3'b100;
                    6:       sz = 3'b101;
                    7:       sz = 3'b011;
                    8:       sz = 3'b110;
                    9:       sz = 3'b111;
                    default: sz = 3'b010;
                endcase
                if ($urandom_range(0, 1) == 0) ad = 9'($urandom_range(0, 31));
                else                           ad = 9'($urandom_range(0, 511));
                if ($urandom_range(0, 3) != 0) ad = ad & ~9'(nbytes(sz) - 1);
                txn(k, wr, ad, sz, $urandom, rd, er);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter DATA_W SHALL default to 32 and give the data width.
REQ-003 Parameter ADDR_W SHALL default to 9 and give the byte-address width; storage is 2**ADDR_W bytes (128 words).
REQ-004 Parameter WAIT_CYCLES SHALL default to 1 and give the number of wait states inserted per access (legal range 0..15).
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port reset  input  1  synchronous active-high reset.
REQ-007 Port req_valid  input  1  request present.
REQ-008 Port req_ready  output  1  request accepted when high together with req_valid.
REQ-009 Port req_wr  input  1  1 = store, 0 = load.
REQ-010 Port req_addr  input  ADDR_W  byte address.
REQ-011 Port req_size  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-012 Port req_wdata  input  DATA_W  store data, LSB-aligned.
REQ-013 Port rsp_valid  output  1  one-cycle response strobe.
REQ-014 Port rsp_rdata  output  DATA_W  load result, extended per req_size.
REQ-015 Port rsp_err  output  1  misaligned or illegal size; valid with rsp_valid.
REQ-016 Port busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL use three states: IDLE, WAIT, RESP.
REQ-018 In IDLE, req_ready SHALL be 1; in WAIT and RESP it SHALL be 0.
REQ-019 On req_valid && req_ready, the block SHALL capture req_wr, req_addr, req_size and req_wdata, then go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-020 In WAIT, a down-counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle; when it reaches 0 the FSM SHALL go to RESP.
REQ-021 The memory access (store commit, load capture into rsp_rdata) SHALL occur on the clock edge that enters RESP.
REQ-022 In RESP, rsp_valid SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE unconditionally.
REQ-023 If a request is accepted at edge N, rsp_valid SHALL be high in the cycle after edge N+1+WAIT_CYCLES; peak throughput is one request per 2+WAIT_CYCLES cycles.
REQ-024 Byte stores SHALL write lane addr[1:0]; half stores SHALL write lanes addr[1]*2+{0,1}; word stores SHALL write all four lanes.
REQ-025 Loads SHALL sign-extend for b/h, zero-extend for bu/hu, and pass w unchanged.
REQ-026 Misalignment (h/hu with addr[0]=1; w with addr[1:0]!=0) or a size of 011/110/111 SHALL set rsp_err=1, suppress the store, and force rsp_rdata=0.
REQ-027 A store's rsp_rdata SHALL be 0 and its rsp_err SHALL follow REQ-026.
REQ-028 rsp_rdata and rsp_err SHALL hold their values until the next RESP entry.
REQ-029 A load following a store to the same address SHALL return the stored data.
REQ-030 req_valid asserted while req_ready=0 SHALL be ignored; the requester holds it.

Reset
REQ-031 Reset SHALL force IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0 and req_ready=1 on the next edge.
REQ-032 Reset SHALL take priority over all transitions; a reset at or before the edge that would enter RESP SHALL abort the request with no store committed.
REQ-033 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-034 Package dmem_pkg SHALL hold the state enum, the size enum (funct3 codes), and the ADDR_W/DATA_W defaults.
REQ-035 Byte-lane steering, write-strobe generation, load extension and the misalignment check SHALL live in one combinational sub-module, dmem_lane_align.
REQ-036 Storage SHALL be a byte-lane array of 2**(ADDR_W-2) words x 4 bytes.

Verification
REQ-037 Store w 0xDEADBEEF at 0x010, then load w at 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after acceptance (WAIT_CYCLES=1).
REQ-038 After REQ-037, load b at 0x013 -> 0xFFFFFFDE; bu at 0x013 -> 0x000000DE; hu at 0x012 -> 0x0000DEAD; h at 0x010 -> 0xFFFFBEEF.
REQ-039 Store h 0x1234 at 0x011 -> rsp_err=1; a subsequent load w at 0x010 still returns 0xDEADBEEF.
REQ-040 With req_valid held high continuously and WAIT_CYCLES=3 -> one acceptance every 5 cycles, req_ready=0 for 4 cycles, and rsp_valid one cycle wide.
REQ-041 Accept store w 0xA5A5A5A5 at 0x020, assert reset in the WAIT cycle -> no rsp_valid, all outputs at reset values, and a later load w at 0x020 returns the prior contents.
REQ-042 With WAIT_CYCLES=0 -> rsp_valid in the cycle after the edge following acceptance; size 011 -> rsp_err=1, rsp_rdata=0.
